// File: rtl/stepper_phase_decoder_if.sv
// rtl/stepper_phase_decoder_if.sv - coil pattern, control strobes and decoded step outputs
interface stepper_phase_decoder_if #(
  parameter int POS_W = 16
);
  logic [3:0]       phase_in;
  logic             clear_pos;
  logic             fault_clr;
  logic [POS_W-1:0] position;
  logic             step_pulse;
  logic             dir;
  logic             locked;
  logic             idle;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output phase_in, clear_pos, fault_clr,
    input  position, step_pulse, dir, locked, idle, fault, fault_code
  );

  modport slave (
    input  phase_in, clear_pos, fault_clr,
    output position, step_pulse, dir, locked, idle, fault, fault_code
  );
endinterface

// File: rtl/stepper_phase_decoder.sv
// rtl/stepper_phase_decoder.sv - half-step coil pattern decoder with debounce and signed position count
module stepper_phase_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stepper_phase_decoder_if.slave bus
);
  localparam logic [3:0]       STABLE  = 4'(STABLE_CYCLES);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  logic [3:0]       sync1, sync2, cand, acc_pat;
  logic [3:0]       stab_cnt, stab_cnt_n;
  logic             same, accept, acc_valid;
  state_t           state, state_n;
  logic             legal;
  logic [2:0]       new_idx, stored_idx, stored_idx_n, delta;
  logic [POS_W-1:0] position_r, position_n;
  logic             step_r, step_n, dir_r, dir_n;
  logic [1:0]       code_r, code_n;
  logic             locked_r, idle_r, fault_r;

  // Count saturates at STABLE so a held pattern is accepted exactly once.
  always_comb begin
    same = (sync2 == cand);
    if (!same)
      stab_cnt_n = 4'd1;
    else if (stab_cnt == STABLE)
      stab_cnt_n = stab_cnt;
    else
      stab_cnt_n = stab_cnt + 4'd1;
    accept = (stab_cnt_n == STABLE) && (!same || (stab_cnt != STABLE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 4'b0000;
      sync2     <= 4'b0000;
      cand      <= 4'b0000;
      stab_cnt  <= 4'd0;
      acc_pat   <= 4'b0000;
      acc_valid <= 1'b0;
    end else begin
      sync1     <= bus.phase_in;
      sync2     <= sync1;
      cand      <= sync2;
      stab_cnt  <= stab_cnt_n;
      acc_valid <= accept;
      if (accept)
        acc_pat <= sync2;
    end
  end

  always_comb begin
    legal   = 1'b1;
    new_idx = 3'd0;
    case (acc_pat)
      4'b0001: new_idx = 3'd0;
      4'b0011: new_idx = 3'd1;
      4'b0010: new_idx = 3'd2;
      4'b0110: new_idx = 3'd3;
      4'b0100: new_idx = 3'd4;
      4'b1100: new_idx = 3'd5;
      4'b1000: new_idx = 3'd6;
      4'b1001: new_idx = 3'd7;
      default: legal = 1'b0;
    endcase
    delta = new_idx - stored_idx;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_UNLOCKED;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_UNLOCKED: begin
        if (acc_valid) begin
          if (legal)
            state_n = ST_LOCKED;
          else if (acc_pat != 4'b0000)
            state_n = ST_FAULT;
        end
      end
      ST_LOCKED: begin
        if (acc_valid) begin
          if (legal) begin
            if ((delta != 3'd0) && (delta != 3'd1) && (delta != 3'd7))
              state_n = ST_FAULT;
          end else if (acc_pat == 4'b0000) begin
            state_n = ST_UNLOCKED;
          end else begin
            state_n = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr)
          state_n = ST_UNLOCKED;
      end
      default: state_n = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    position_n   = position_r;
    step_n       = 1'b0;
    dir_n        = dir_r;
    code_n       = code_r;
    stored_idx_n = stored_idx;
    case (state)
      ST_UNLOCKED: begin
        if (acc_valid) begin
          if (legal)
            stored_idx_n = new_idx;
          else if (acc_pat != 4'b0000)
            code_n = 2'b01;
        end
      end
      ST_LOCKED: begin
        if (acc_valid) begin
          if (legal) begin
            stored_idx_n = new_idx;
            if (delta == 3'd1) begin
              position_n = position_r + POS_ONE;
              dir_n      = 1'b1;
              step_n     = 1'b1;
            end else if (delta == 3'd7) begin
              position_n = position_r - POS_ONE;
              dir_n      = 1'b0;
              step_n     = 1'b1;
            end else if (delta != 3'd0) begin
              code_n = 2'b10;
            end
          end else if (acc_pat != 4'b0000) begin
            code_n = 2'b01;
          end
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr)
          code_n = 2'b00;
      end
      default: ;
    endcase
    // Clearing wins over the count but the step strobe and direction still report.
    if (bus.clear_pos)
      position_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      position_r <= '0;
      step_r     <= 1'b0;
      dir_r      <= 1'b1;
      code_r     <= 2'b00;
      stored_idx <= 3'd0;
      locked_r   <= 1'b0;
      idle_r     <= 1'b1;
      fault_r    <= 1'b0;
    end else begin
      position_r <= position_n;
      step_r     <= step_n;
      dir_r      <= dir_n;
      code_r     <= code_n;
      stored_idx <= stored_idx_n;
      locked_r   <= (state_n == ST_LOCKED);
      idle_r     <= (acc_pat == 4'b0000);
      fault_r    <= (state_n == ST_FAULT);
    end
  end

  assign bus.position   = position_r;
  assign bus.step_pulse = step_r;
  assign bus.dir        = dir_r;
  assign bus.locked     = locked_r;
  assign bus.idle       = idle_r;
  assign bus.fault      = fault_r;
  assign bus.fault_code = code_r;
endmodule
